// File: rtl/decade_timer_ctrl.sv
// decade_timer_ctrl: presettable BCD up/down decade timer with prescaler and run FSM; define AUTO_RELOAD_EN to reload the preset at terminal instead of stopping
module decade_timer_ctrl #(
  parameter int NDIG = 4,
  parameter int PRESCALE = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  input  logic              clear,
  input  logic              dir_up,
  input  logic              preset_valid,
  input  logic [4*NDIG-1:0] preset_bcd,
  output logic [4*NDIG-1:0] digits,
  output logic              running,
  output logic              done,
  output logic              tick,
  output logic              wrap
);
  localparam int W = 4 * NDIG;
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);
  localparam logic [W-1:0] NINES = {NDIG{4'h9}};
`ifdef AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t state, nxt;
  logic [PW-1:0] presc;
  logic [W-1:0] saved, stepped, term, loaded;
  logic tk, ld, hit;

  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < NDIG; i++)
      r[4*i +: 4] = v[4*i +: 4] > 4'd9 ? 4'd9 : v[4*i +: 4];
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v, input logic up);
    logic [W-1:0] r;
    logic c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (c) begin
        r[4*i +: 4] = up ? (v[4*i +: 4] == 4'd9 ? 4'd0 : v[4*i +: 4] + 4'd1)
                         : (v[4*i +: 4] == 4'd0 ? 4'd9 : v[4*i +: 4] - 4'd1);
        c = up ? v[4*i +: 4] == 4'd9 : v[4*i +: 4] == 4'd0;
      end
    end
    return r;
  endfunction

  // command decode and next state, priority clear > preset_valid > pause > start
  always_comb begin
    ld = !clear && preset_valid && state != RUN;
    tk = state == RUN && !clear && !pause && presc == PLAST;
    stepped = bcd_step(digits, dir_up);
    term = dir_up ? NINES : '0;
    hit = digits == term || stepped == term;
    loaded = bcd_clamp(preset_bcd);
    nxt = (clear || ld) ? IDLE :
          ((state == IDLE || state == PAUSE) && start && !pause) ? RUN :
          (state == RUN && pause) ? PAUSE :
          (tk && hit && !AUTO) ? DONE : state;
  end

  // FSM state, prescaler, digit cascade and registered status flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      presc <= '0;
      digits <= '0;
      saved <= '0;
      running <= 1'b0;
      done <= 1'b0;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else begin
      state <= nxt;
      running <= nxt == RUN;
      done <= nxt == DONE;
      tick <= tk;
      wrap <= AUTO && tk && hit;
      presc <= (clear || ld || state == IDLE) ? '0 :
               (state == RUN && !pause) ? (presc == PLAST ? '0 : presc + 1'b1) : presc;
      digits <= clear ? '0 : ld ? loaded : !tk ? digits : !hit ? stepped : AUTO ? saved : term;
      saved <= ld ? loaded : saved;
    end
  end
endmodule

// File: tb/tb_decade_timer_ctrl.sv
// tb_decade_timer_ctrl: directed and randomized bench against an integer-valued timer model
module tb_decade_timer_ctrl;
  localparam int NDIG = 4;
  localparam int PRESCALE = 4;
  localparam int W = 4 * NDIG;
  localparam int MAXV = 10 ** NDIG - 1;
`ifdef AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
  logic dir_up = 1'b0, preset_valid = 1'b0;
  logic [W-1:0] preset_bcd = '0;
  logic [W-1:0] digits;
  logic running, done, tick, wrap;
  logic [W+3:0] obs;
  int n_chk = 0, n_pass = 0;
  int m_val = 0, m_saved = 0, m_cnt = 0, m_mode = 0;
  bit m_tick = 1'b0, m_wrap = 1'b0;

  decade_timer_ctrl #(.NDIG(NDIG), .PRESCALE(PRESCALE)) dut (
    .clock(clock), .reset(reset), .start(start), .pause(pause), .clear(clear),
    .dir_up(dir_up), .preset_valid(preset_valid), .preset_bcd(preset_bcd),
    .digits(digits), .running(running), .done(done), .tick(tick), .wrap(wrap)
  );

  assign obs = {digits, running, done, tick, wrap};
  always #5 clock = ~clock;

  function automatic int bcd2int(input logic [W-1:0] b);
    int v = 0;
    for (int i = NDIG - 1; i >= 0; i--)
      v = v * 10 + ((b[4*i +: 4] > 4'd9) ? 9 : int'(b[4*i +: 4]));
    return v;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] b;
    for (int i = 0; i < NDIG; i++) begin
      b[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return b;
  endfunction

  task automatic chk(input string nm, input logic [W+3:0] a, input logic [W+3:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", nm, a, e, $time);
  endtask

  task automatic m_reset();
    m_val = 0; m_saved = 0; m_cnt = 0; m_mode = 0; m_tick = 0; m_wrap = 0;
  endtask

  // mode: 0 idle, 1 run, 2 pause, 3 done; value held as a plain integer
  task automatic step();
    int tgt, nx;
    if (!reset) m_reset();
    else begin
      m_tick = 0; m_wrap = 0;
      if (clear) begin m_mode = 0; m_val = 0; m_cnt = 0; end
      else if (preset_valid && m_mode != 1) begin
        m_val = bcd2int(preset_bcd); m_saved = m_val; m_mode = 0; m_cnt = 0;
      end else if (m_mode == 1) begin
        if (pause) m_mode = 2;
        else if (m_cnt < PRESCALE - 1) m_cnt++;
        else begin
          m_cnt = 0; m_tick = 1;
          tgt = dir_up ? MAXV : 0;
          nx = dir_up ? m_val + 1 : m_val - 1;
          if (m_val == tgt || nx == tgt) begin
            if (AUTO) begin m_val = m_saved; m_wrap = 1; end
            else begin m_val = tgt; m_mode = 3; end
          end else m_val = nx;
        end
      end else if ((m_mode == 0 || m_mode == 2) && start && !pause) begin
        if (m_mode == 0) m_cnt = 0;
        m_mode = 1;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    step();
    @(negedge clock);
    chk("model", obs, {int2bcd(m_val), m_mode == 1, m_mode == 3, m_tick, m_wrap});
  endtask

  task automatic load(input logic [W-1:0] p);
    preset_bcd = p; preset_valid = 1; cyc(); preset_valid = 0;
  endtask

  initial begin
    int r, k;
    cyc(); cyc();
    reset = 1; cyc();
    chk("reset_state", obs, 20'h0);
    load(16'h0098);
    chk("preset_load", obs, {16'h0098, 4'b0000});
    dir_up = 1; start = 1; cyc(); start = 0;
    chk("start_running", obs, {16'h0098, 4'b1000});
    repeat (3) cyc();
    chk("no_early_tick", obs, {16'h0098, 4'b1000});
    cyc();
    chk("tick_0099", obs, {16'h0099, 4'b1010});
    repeat (4) cyc();
    chk("carry_0100", obs, {16'h0100, 4'b1010});
    clear = 1; cyc(); clear = 0;
    load(16'h0002);
    dir_up = 0; start = 1; cyc(); start = 0;
    repeat (4) cyc();
    chk("down_0001", obs, {16'h0001, 4'b1010});
    repeat (4) cyc();
`ifdef AUTO_RELOAD_EN
    chk("down_reload", obs, {16'h0002, 4'b1011});
`else
    chk("down_done", obs, {16'h0000, 4'b0110});
    start = 1; cyc(); start = 0;
    repeat (5) cyc();
    chk("done_holds", obs, {16'h0000, 4'b0100});
`endif
    clear = 1; cyc(); clear = 0;
    chk("clear_idle", obs, 20'h0);
    load(16'h0050);
    dir_up = 1; start = 1; cyc(); start = 0;
    repeat (2) cyc();
    pause = 1; cyc(); pause = 0;
    chk("paused", obs, {16'h0050, 4'b0000});
    repeat (20) cyc();
    chk("pause_hold", obs, {16'h0050, 4'b0000});
    start = 1; cyc(); start = 0;
    chk("resume", obs, {16'h0050, 4'b1000});
    cyc();
    chk("resume_no_tick", obs, {16'h0050, 4'b1000});
    cyc();
    chk("resume_tick", obs, {16'h0051, 4'b1010});
    load(16'h1234);
    chk("preset_in_run", obs, {16'h0051, 4'b1000});
    pause = 1; start = 1; cyc(); pause = 0; start = 0;
    chk("pause_wins", obs, {16'h0051, 4'b0000});
    clear = 1; preset_valid = 1; start = 1; cyc(); clear = 0; preset_valid = 0; start = 0;
    chk("clear_priority", obs, 20'h0);
    load(16'h0C3C);
    chk("clamp", obs, {16'h0939, 4'b0000});
    load(16'h9997);
    dir_up = 1; start = 1; cyc(); start = 0;
    repeat (4) cyc();
    chk("up_9998", obs, {16'h9998, 4'b1010});
    repeat (4) cyc();
`ifdef AUTO_RELOAD_EN
    chk("reload_wrap", obs, {16'h9997, 4'b1011});
`else
    chk("up_done", obs, {16'h9999, 4'b0110});
`endif
    clear = 1; cyc(); clear = 0;
    load(16'h0500);
    start = 1; cyc(); start = 0;
    repeat (4) cyc();
    #2 reset = 0;
    #1 m_reset();
    chk("async_reset", obs, 20'h0);
    cyc(); reset = 1; cyc();
    for (int c = 0; c < 4000; c++) begin
      clear = $urandom_range(0, 999) < 15;
      preset_valid = $urandom_range(0, 99) < 6;
      k = $urandom_range(0, 99);
      pause = k < 6;
      start = k >= 6 && k < 30;
      if ($urandom_range(0, 9) == 0) dir_up = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 4);
      preset_bcd = r == 0 ? 16'($urandom) : r == 1 ? {12'h999, 4'($urandom_range(0, 15))} :
                   r == 2 ? {12'h000, 4'($urandom_range(0, 15))} : r == 3 ? 16'h9999 : 16'h0000;
      if ($urandom_range(0, 999) < 3) begin
        #2 reset = 0;
        #1 m_reset();
        chk("rand_async_reset", obs, 20'h0);
      end else reset = 1;
      cyc();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
